// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered full/empty flags and occupancy.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
    parameter int data_size = 8,
    parameter int depth     = 16,
    localparam int addr_w   = $clog2(depth)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [data_size-1:0] data_in,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic [data_size-1:0] data_out,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic [addr_w:0]      fill_count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    localparam logic [addr_w:0] full_cnt = (addr_w + 1)'(depth);

    logic [data_size-1:0] mem [depth];
    logic [addr_w-1:0]    wr_ptr;
    logic [addr_w-1:0]    rd_ptr;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [addr_w:0]      count_next;

    // Handshake: a request is taken on the edge where its enable is high and the
    // registered flags allow it; a full FIFO still takes a write if a read frees a slot.
    always_comb begin
        rd_acc = read_en && !fifo_empty;
        wr_acc = write_en && (!fifo_full || rd_acc);
    end

    always_comb begin
        count_next = fill_count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = fill_count + 1'b1;
            2'b01:   count_next = fill_count - 1'b1;
            default: count_next = fill_count;
        endcase
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (reset && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            data_out   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            fill_count <= count_next;
            fifo_full  <= (count_next == full_cnt);
            fifo_empty <= (count_next == '0);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (read_en && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO that is the design under test behind fifo_if.
- Responds to the driver side: data_in, write_en and read_en in; data_out, fifo_full and fifo_empty out.
- Circular buffer with read/write pointers and an occupancy counter.
- Registered read data and registered status flags, so the monitor samples stable values at posedge clock.

Parameters:
- data_size, 8, width of each stored word in bits.
- depth, 16, number of entries. Must be a power of two and at least 2.
- addr_w, $clog2(depth), pointer width. Derived; must not be overridden.

Ports:
- clock  input  1  sole clock; all logic is on posedge clock.
- reset  input  1  reset is synchronous and active-low (reset==0 at posedge clock resets the block).
- data_in  input  data_size  write data.
- write_en  input  1  write request.
- read_en  input  1  read request.
- data_out  output  data_size  registered read data.
- fifo_full  output  1  registered; high when count==depth.
- fifo_empty  output  1  registered; high when count==0.
- fill_count  output  addr_w+1  registered occupancy, range 0..depth.
- overflow  output  1  present only with FIFO_ERR_FLAGS_EN.
- underflow  output  1  present only with FIFO_ERR_FLAGS_EN.

Behaviour:
- Reset (reset==0 at posedge clock):
  - wr_ptr=0, rd_ptr=0, fill_count=0.
  - fifo_empty=1, fifo_full=0, data_out=0.
  - Storage array is not reset.
  - Reset takes priority over any write_en/read_en in the same cycle. Reset mid-stream discards all contents.
- Accept rules, evaluated on the registered flags at the edge:
  - wr_acc = write_en && (!fifo_full || rd_acc).
  - rd_acc = read_en && !fifo_empty.
- Write: when wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments mod depth (natural wrap of addr_w bits).
- Read latency is 1 cycle:
  - When rd_acc, data_out <= mem[rd_ptr] and rd_ptr increments mod depth.
  - data_out is visible after the same edge.
  - data_out holds its last value when there is no read.
- Counter update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both or neither: unchanged.
  - fifo_full and fifo_empty are recomputed from the next count value, so they are valid the cycle after the edge. No combinational paths from inputs to outputs.
- Simultaneous events:
  - Full with write_en and read_en: read and write both accepted; count stays at depth; fifo_full stays 1.
  - Empty with write_en and read_en: write accepted, read ignored (no fall-through); data_out unchanged; count becomes 1.
- Write while full with no read: dropped. Data, pointers and count unchanged.
- Read while empty: ignored. data_out holds.
- Ordering: strict FIFO. Pointers may wrap any number of times without data loss.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - Ports overflow and underflow exist. Both reset to 0.
  - overflow sets (sticky) on the edge where write_en && !wr_acc.
  - underflow sets (sticky) on the edge where read_en && fifo_empty.
  - Both clear only on reset.
- Undefined: both ports and all associated logic are absent. Dropped writes and ignored reads occur silently.

Test Plan:
1. Reset, then idle 3 cycles -> fifo_empty=1, fifo_full=0, fill_count=0, data_out=0. Assert read_en for 1 cycle -> data_out stays 0; underflow=1 with FIFO_ERR_FLAGS_EN.
2. Write 0x01..0x10 (16 writes), then read 16 -> fifo_full=1 after the 16th write edge; data_out = 0x01..0x10 in order, one per read, 1-cycle latency; fifo_empty=1 after the last read.
3. FIFO full, write 0xAA with no read -> 0xAA dropped, fill_count=16, overflow=1 when enabled; subsequent 16 reads return 0x01..0x10 with no 0xAA.
4. FIFO full, write_en=1 data_in=0x55 together with read_en=1 -> data_out=0x01, fill_count stays 16, fifo_full stays 1; draining yields 0x02..0x10 then 0x55.
5. FIFO empty, write_en=1 data_in=0x3C together with read_en=1 -> data_out unchanged, fill_count=1, fifo_empty=0; next read returns 0x3C.
6. Random traffic over 40 wraps, with reset asserted mid-stream at fill_count=7 -> all outputs return to reset values on that edge; scoreboard is flushed; ordering is correct before and after the reset.
